ahb_sram_slave: RTL

AHB-Lite responder with an internal word-addressed SRAM, a configurable number of wait states and an ERROR response. It is the target for the FIC AHB master that writes RAM at init, and lets master-side benches run against a real slave instead of tied-off HREADY/HRESP/HRDATA. It handles byte, halfword and word transfers, and single and burst transfers, with little-endian byte lanes.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_byte_strobe.sv | 20 ++
 rtl/ahb_sram_slave.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's data-phase state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for a transfer of the given size and low address bits.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb_c
);

  always_comb begin
    strb_c = 4'b0000;
    case (size)
      HSIZE_BYTE: strb_c = 4'b0001 << addr;
      HSIZE_HALF: strb_c = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb_c = 4'b1111;
      default:    strb_c = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-addressed SRAM, with optional wait
// states and a two-cycle ERROR response for bad size/alignment/range.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned LA_W   = MEM_AW + 2;
  localparam int unsigned CNT_W  = 4;

  slv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;

  logic              accept_c;
  logic              addr_err_c;
  logic              mem_we_c;
  logic [3:0]        strb_c;
  logic [MEM_AW-1:0] widx_c;
  logic [31:0]       mem [MEM_DEPTH];

  logic              unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HADDR[31:ADDR_WIDTH], HTRANS[0]};

  assign accept_c   = HSEL & HREADYIN & HTRANS[1];
  assign addr_err_c = (HSIZE > HSIZE_WORD)
                    | ((HSIZE == HSIZE_HALF) & HADDR[0])
                    | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                    | (32'(HADDR[ADDR_WIDTH-1:2]) >= 32'(MEM_DEPTH));

  assign widx_c   = addr_q[LA_W-1:2];
  assign mem_we_c = (state_q == ST_DATA) & write_q;

  ahb_byte_strobe u_strobe (
    .size   (size_q),
    .addr   (addr_q[1:0]),
    .strb_c (strb_c)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with the bus ready, so a new address phase may land here
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d  = HADDR[LA_W-1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (addr_err_c) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: HRDATA    = mem[widx_c];
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Memory is deliberately not reset; only the enabled lanes change.
  always_ff @(posedge HCLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_c[b]) mem[widx_c][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule
